// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: branch FSM states, forwarding select codes,
// shadow destination record, and instruction field positions.
package pipe_pkg;

  localparam int PIPE_RA_W = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BR_EX    = 2'd1,
    BR_FLUSH = 2'd2
  } br_state_t;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic                 wr_en;
    logic [PIPE_RA_W-1:0] rd;
    logic                 is_load;
  } shadow_t;

  localparam shadow_t SHADOW_NONE = '0;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against one in-flight destination record.
// Register 0 is hardwired to zero and never matches.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int RA_W = PIPE_RA_W
) (
  input  logic            i_valid,
  input  logic            i_wr_en,
  input  logic [RA_W-1:0] i_reg,
  input  logic [RA_W-1:0] i_src,
  input  logic            i_use,
  output logic            o_match
);

  assign o_match = i_valid & i_wr_en & i_use & (i_reg != '0) & (i_reg == i_src);

endmodule

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage pipeline: load-use/RAW stalls, branch hold
// and flush, forwarding selects. HAZ_PERF_CNT_EN adds stall/flush counters.
//
// state    | meaning
// IDLE     | no branch in flight; only data hazards stall
// BR_EX    | branch in EX awaiting resolution; fetch held
// BR_FLUSH | taken branch redirected; squashed slot bubbles into EX
module hazard_sched
  import pipe_pkg::*;
#(
  parameter int RA_W       = PIPE_RA_W,
  parameter bit FWD_EN_DEF = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_wr_en,
  input  logic [RA_W-1:0] id_wr_reg,
  input  logic            id_is_load,
  input  logic            id_is_branch,
  input  logic            ex_br_resolved,
  input  logic            ex_br_taken,
  output logic            stall_if,
  output logic            bubble_ex,
  output logic            flush_ifid,
  output logic            pc_redirect,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]     perf_stall_cnt,
  output logic [15:0]     perf_flush_cnt,
`endif
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel
);

  // WB writes reach readers through register-file write-before-read, so only
  // the EX and MEM records take part in any decision. RA_W must equal PIPE_RA_W.
  shadow_t   r_ex, r_mem;
  br_state_t r_state, w_state_nxt;
  logic [1:0] r_fwd_a, r_fwd_b, w_fwd_a, w_fwd_b;
  logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
  logic w_lu, w_raw, w_data_stall;
  logic w_stall, w_bubble, w_flush;

  hazard_match #(.RA_W(RA_W)) u_ex_rs (
    .i_valid(r_ex.valid), .i_wr_en(r_ex.wr_en), .i_reg(r_ex.rd),
    .i_src(id_rs), .i_use(id_use_rs), .o_match(w_ex_rs));
  hazard_match #(.RA_W(RA_W)) u_ex_rt (
    .i_valid(r_ex.valid), .i_wr_en(r_ex.wr_en), .i_reg(r_ex.rd),
    .i_src(id_rt), .i_use(id_use_rt), .o_match(w_ex_rt));
  hazard_match #(.RA_W(RA_W)) u_mem_rs (
    .i_valid(r_mem.valid), .i_wr_en(r_mem.wr_en), .i_reg(r_mem.rd),
    .i_src(id_rs), .i_use(id_use_rs), .o_match(w_mem_rs));
  hazard_match #(.RA_W(RA_W)) u_mem_rt (
    .i_valid(r_mem.valid), .i_wr_en(r_mem.wr_en), .i_reg(r_mem.rd),
    .i_src(id_rt), .i_use(id_use_rt), .o_match(w_mem_rt));

  always_comb begin
    w_lu         = r_ex.is_load & (w_ex_rs | w_ex_rt);
    w_raw        = FWD_EN_DEF ? 1'b0 : (w_ex_rs | w_ex_rt | w_mem_rs | w_mem_rt);
    w_data_stall = w_lu | w_raw;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall  = w_data_stall;
        w_bubble = w_data_stall;
        if (id_valid && id_is_branch && !w_data_stall) w_state_nxt = BR_EX;
      end
      BR_EX: begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        if (ex_br_resolved) begin
          if (ex_br_taken) begin
            w_flush     = 1'b1;
            w_state_nxt = BR_FLUSH;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      BR_FLUSH: begin
        w_bubble    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Reset abandons any branch or stall in progress without flushing.
    if (reset) begin
      w_stall     = 1'b0;
      w_bubble    = 1'b0;
      w_flush     = 1'b0;
      w_state_nxt = IDLE;
    end
  end

  always_comb begin
    w_fwd_a = FWD_RF;
    w_fwd_b = FWD_RF;
    if (FWD_EN_DEF) begin
      if (w_ex_rs)       w_fwd_a = FWD_EXMEM;
      else if (w_mem_rs) w_fwd_a = FWD_MEMWB;
      if (w_ex_rt)       w_fwd_b = FWD_EXMEM;
      else if (w_mem_rt) w_fwd_b = FWD_MEMWB;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_ex    <= SHADOW_NONE;
      r_mem   <= SHADOW_NONE;
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else begin
      r_state <= w_state_nxt;
      r_mem   <= r_ex;
      if (w_bubble) begin
        r_ex    <= SHADOW_NONE;
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
      end else begin
        r_ex    <= '{valid: id_valid, wr_en: id_wr_en, rd: id_wr_reg, is_load: id_is_load};
        r_fwd_a <= w_fwd_a;
        r_fwd_b <= w_fwd_b;
      end
    end
  end

  assign stall_if    = w_stall;
  assign bubble_ex   = w_bubble;
  assign flush_ifid  = w_flush;
  assign pc_redirect = w_flush;
  assign fwd_a_sel   = r_fwd_a;
  assign fwd_b_sel   = r_fwd_b;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + {31'd0, w_stall};
      r_flush_cnt <= r_flush_cnt + {15'd0, w_flush};
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: directed program snippets then random
// instruction streams, checked against a per-instruction pipeline model.
module tb_hazard_sched;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic       id_wr_en = 1'b0, id_is_load = 1'b0, id_is_branch = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wr_reg = '0;
  logic       ex_br_resolved = 1'b0, ex_br_taken = 1'b0;
  logic       stall_if, bubble_ex, flush_ifid, pc_redirect;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  hazard_sched dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch),
    .ex_br_resolved(ex_br_resolved), .ex_br_taken(ex_br_taken),
    .stall_if(stall_if), .bubble_ex(bubble_ex),
    .flush_ifid(flush_ifid), .pc_redirect(pc_redirect),
`ifdef HAZ_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel));

  always #5 clock = ~clock;

  typedef struct packed {
    logic        st, bu, fl;
    logic [1:0]  fa, fb;
    logic        chk;
    logic [31:0] sc;
    logic [15:0] fc;
  } exp_t;

  typedef struct {
    bit v;
    bit wr;
    int rd;
    bit ld;
  } ins_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: instructions occupying EX and MEM, branch progress, forwarding regs.
  ins_t        m_ex, m_mem;
  int          m_br;        // 0 none, 1 branch waiting in EX, 2 squash slot
  int          m_fa, m_fb;
  bit          m_known = 1'b0;
  int unsigned m_sc, m_fc;

  function automatic bit hits(ins_t e, int r, bit u);
    return u && e.v && e.wr && e.rd != 0 && e.rd == r;
  endfunction

  task automatic cyc(input bit rst, input bit v, input int rs, input int rt,
                     input bit urs, input bit urt, input bit wr, input int wreg,
                     input bit ld, input bit br, input bit res, input bit tk);
    exp_t e;
    bit   st, bu, fl;
    int   nfa, nfb;
    ins_t nop_i;
    reset = rst; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt);
    id_use_rs = urs; id_use_rt = urt; id_wr_en = wr; id_wr_reg = 5'(wreg);
    id_is_load = ld; id_is_branch = br; ex_br_resolved = res; ex_br_taken = tk;
    st = 0; bu = 0; fl = 0;
    if (!rst) begin
      if (m_br == 1) begin
        st = 1; bu = 1; fl = res && tk;
      end else if (m_br == 2) begin
        bu = 1;
      end else begin
        st = m_ex.ld && (hits(m_ex, rs, urs) || hits(m_ex, rt, urt));
        bu = st;
      end
    end
    e = '0;
    e.st = st; e.bu = bu; e.fl = fl;
    e.fa = 2'(m_fa); e.fb = 2'(m_fb); e.chk = m_known;
    e.sc = m_sc; e.fc = 16'(m_fc);
    q.push_back(e);
    nop_i = '{v: 0, wr: 0, rd: 0, ld: 0};
    if (rst) begin
      m_ex = nop_i; m_mem = nop_i; m_br = 0; m_fa = 0; m_fb = 0;
      m_known = 1; m_sc = 0; m_fc = 0;
    end else begin
      m_sc = m_sc + st;
      m_fc = (m_fc + fl) & 32'hFFFF;
      if (m_br == 0) m_br = (v && br && !st) ? 1 : 0;
      else if (m_br == 1) m_br = res ? (tk ? 2 : 0) : 1;
      else m_br = 0;
      if (bu) begin
        nfa = 0; nfb = 0;
      end else begin
        nfa = hits(m_ex, rs, urs) ? 1 : (hits(m_mem, rs, urs) ? 2 : 0);
        nfb = hits(m_ex, rt, urt) ? 1 : (hits(m_mem, rt, urt) ? 2 : 0);
      end
      m_fa = nfa; m_fb = nfb;
      m_mem = m_ex;
      m_ex = bu ? nop_i : '{v: v, wr: wr, rd: wreg, ld: ld};
    end
    @(posedge clock);
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  exp_t me;
  initial begin
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        me = q.pop_front();
        checks++;
        if ({stall_if, bubble_ex, flush_ifid, pc_redirect} !== {me.st, me.bu, me.fl, me.fl}) begin
          errors++;
          $display("FAIL ctrl t=%0t: stall/bubble/flush/redir got %b%b%b%b exp %b%b%b%b",
                   $time, stall_if, bubble_ex, flush_ifid, pc_redirect, me.st, me.bu, me.fl, me.fl);
        end
        if (me.chk) begin
          checks++;
          if (fwd_a_sel !== me.fa || fwd_b_sel !== me.fb) begin
            errors++;
            $display("FAIL fwd t=%0t: a/b got %0d/%0d exp %0d/%0d",
                     $time, fwd_a_sel, fwd_b_sel, me.fa, me.fb);
          end
`ifdef HAZ_PERF_CNT_EN
          checks++;
          if (perf_stall_cnt !== me.sc || perf_flush_cnt !== me.fc) begin
            errors++;
            $display("FAIL perf t=%0t: stall/flush cnt got %0d/%0d exp %0d/%0d",
                     $time, perf_stall_cnt, perf_flush_cnt, me.sc, me.fc);
          end
`endif
        end
      end
    end
  end

  initial begin
    bit v, br, ld, wr;
    @(posedge clock);
    #1;
    //  rst v  rs rt urs urt wr wreg ld br res tk
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(1);
    // lw $8 ; add $9,$8,$8 (held one cycle by load-use)
    cyc(0, 1, 29, 8, 1, 0, 1, 8, 1, 0, 0, 0);
    cyc(0, 1, 8, 8, 1, 1, 1, 9, 0, 0, 0, 0);
    cyc(0, 1, 8, 8, 1, 1, 1, 9, 0, 0, 0, 0);
    nop(2);
    // add $3,$1,$2 ; sub $4,$3,$5
    cyc(0, 1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0);
    cyc(0, 1, 3, 5, 1, 1, 1, 4, 0, 0, 0, 0);
    nop(2);
    // lw $0 ; add $0 ; reader of $0
    cyc(0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 1, 1, 6, 0, 0, 0, 0);
    nop(2);
    // beq taken, resolved on its first EX cycle
    cyc(0, 1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 4, 5, 1, 1, 1, 7, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    nop(2);
    // bne resolved after 3 waiting cycles, not taken
    cyc(0, 1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 4, 5, 1, 1, 1, 7, 0, 0, 0, 0);
    cyc(0, 1, 4, 5, 1, 1, 1, 7, 0, 0, 1, 0);
    nop(2);
    // reset while branch waits in EX with a load-use candidate in ID
    cyc(0, 1, 1, 0, 1, 0, 1, 8, 1, 0, 0, 0);
    cyc(0, 1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 8, 8, 1, 1, 1, 9, 0, 0, 0, 0);
    cyc(1, 1, 8, 8, 1, 1, 1, 9, 0, 0, 0, 0);
    nop(3);
    for (int n = 0; n < 3000; n++) begin
      v  = ($urandom_range(0, 7) != 0);
      br = v && ($urandom_range(0, 7) == 0);
      ld = v && !br && ($urandom_range(0, 2) == 0);
      wr = v && !br && ($urandom_range(0, 4) != 0);
      cyc($urandom_range(0, 59) == 0, v,
          v ? int'($urandom_range(0, 3)) : 0, v ? int'($urandom_range(0, 3)) : 0,
          v && $urandom_range(0, 1) == 1, v && $urandom_range(0, 1) == 1,
          wr, wr ? int'($urandom_range(0, 3)) : 0, ld, br,
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end
    nop(4);
    repeat (3) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d records left, exp 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline hazard scheduler for the 5-stage static MIPS pipeline (IF/ID/EX/MEM/WB).
- Keeps a shadow record of destination registers for the EX, MEM and WB stages.
- Drives IF/ID stall, EX bubble, branch hold/flush and operand-forwarding selects.
- Replaces the instruction-type-grouping stall scheme in the pipeline control logic with per-hazard scheduling.

Parameters:
- RA_W, 5, register-address width.
- FWD_EN_DEF, 1, 1 = forwarding selects are generated; 0 = fwd_a_sel/fwd_b_sel are held at 0 and every RAW hazard against EX/MEM stalls instead.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real (non-NOP) instruction
- id_rs  in  RA_W  ID source reg (ir[25:21])
- id_rt  in  RA_W  ID source reg (ir[20:16])
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_wr_en  in  1  instruction writes a register
- id_wr_reg  in  RA_W  destination (rd or rt, already muxed)
- id_is_load  in  1  lw
- id_is_branch  in  1  beq/bne
- ex_br_resolved  in  1  branch condition valid in EX this cycle
- ex_br_taken  in  1  qualified by ex_br_resolved
- stall_if  out  1  hold pc and IF/ID register (combinational)
- bubble_ex  out  1  load NOP into ID/EX instead of ID instruction (combinational)
- flush_ifid  out  1  replace IF/ID contents with NOP (combinational)
- pc_redirect  out  1  load branch target into pc (combinational, equals flush_ifid)
- fwd_a_sel  out  2  operand A source for instruction now in EX: 0 = rf, 1 = EX/MEM result, 2 = MEM/WB result (registered)
- fwd_b_sel  out  2  same for operand B (registered)

Behaviour:
- Reset (synchronous, active-high; clock is `clock`, reset is `reset`):
  - shadow EX/MEM/WB entries invalid; FSM = IDLE.
  - All outputs 0: stall_if, bubble_ex, flush_ifid, pc_redirect combinationally, fwd_*_sel by register.
  - Reset asserted mid-branch or mid-stall abandons it; no flush is issued.
- Shadow entry = {valid, wr_en, reg, is_load}. Each cycle WB<=MEM, MEM<=EX, EX<=(bubble_ex ? invalid : ID fields).
- Register 0 never matches (no hazard, no forwarding).
- Load-use: EX entry valid & is_load & wr_en & reg≠0 & ((id_use_rs & reg==id_rs) | (id_use_rt & reg==id_rt)) -> stall_if=1, bubble_ex=1 for exactly one cycle.
- With FWD_EN_DEF=0, additionally stall while any valid writing EX or MEM entry matches an ID source.
- Forwarding (FWD_EN_DEF=1), computed when ID->EX advances, registered into fwd_*_sel:
  - EX-entry match -> 1; else MEM-entry match -> 2; else 0. EX has priority over MEM (youngest wins).
  - On bubble the selects register 0.
- WB-stage writes are covered by register-file write-before-read; no forwarding path.
- Branch FSM, states IDLE, BR_EX, BR_FLUSH:
  - IDLE -> BR_EX when the branch advances ID->EX (id_valid & id_is_branch & !stall_if).
  - BR_EX: stall_if=1, bubble_ex=1 (no fetch past branch).
    - On ex_br_resolved & ex_br_taken -> flush_ifid=1, pc_redirect=1 that cycle, then BR_FLUSH.
    - On ex_br_resolved & !taken -> IDLE, release next cycle.
    - With no ex_br_resolved, remain in BR_EX indefinitely.
  - BR_FLUSH: one cycle, stall_if=0, bubble_ex=1 (the squashed slot), then IDLE.
- Simultaneous events:
  - Load-use and branch in ID: load-use stall first; branch enters BR_EX only when it actually advances.
  - stall_if asserted by both sources is a single stall.
  - ex_br_resolved while in IDLE is ignored.
- Latency: stall decision in the same cycle as the hazard; forwarding selects valid the first cycle the consumer is in EX.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt[31:0] (counts cycles with stall_if=1) and perf_flush_cnt[15:0] (counts flush_ifid pulses).
  - Both counters are synchronously cleared by reset and wrap silently at maximum.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - FSM state enum {IDLE, BR_EX, BR_FLUSH}.
  - FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2.
  - Shadow-entry struct.
  - NOP constant and opcode field positions, also used by the pipeline control logic.
- Sub-module hazard_match: combinational source-vs-entry comparator (valid, wr_en, reg≠0, use bits), instanced four times for EX/MEM × rs/rt.

Test Plan:
- lw $8 then add $9,$8,$8 -> stall_if=1 and bubble_ex=1 for exactly 1 cycle, then fwd_a_sel=fwd_b_sel=2 while the add is in EX.
- add $3,$1,$2 then sub $4,$3,$5 -> no stall; fwd_a_sel=1, fwd_b_sel=0 in the sub's EX cycle.
- Writes to $0 followed by a reader of $0 -> no stall, all selects 0.
- beq taken, resolved the first EX cycle -> stall_if high 1 cycle, flush_ifid/pc_redirect pulse 1 cycle, bubble_ex 2 cycles total, FSM returns to IDLE.
- bne with ex_br_resolved delayed 3 cycles, then not-taken -> stall_if high 3 cycles then 1 cycle, no flush.
- reset asserted while in BR_EX with a pending load-use -> next cycle all outputs 0, FSM IDLE; with HAZ_PERF_CNT_EN defined, counters read 0.
